// File: rtl/rgb_to_yuv_converter.sv
// RGB to YUV frame converter.
// Reads planar-interleaved RGB words (R, G, B per two-pixel pair), converts each pixel to
// 8-bit Y/U/V with saturation and writes the Y, U and V words to three separate planes.
// Optional feature macro: RGB2YUV_ROUND_EN adds a rounding constant of 128 before the
// final shift (round to nearest); without it the result truncates toward minus infinity.
module rgb_to_yuv_converter #(
  parameter int unsigned PIXEL_PAIRS = 38400,
  parameter logic [19:0] Y_BASE      = 20'd0,
  parameter logic [19:0] U_BASE      = 20'd38400,
  parameter logic [19:0] V_BASE      = 20'd76800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] R_data,
  output logic [19:0] R_addr,
  output logic [19:0] W_addr,
  output logic [15:0] W_data,
  output logic        W_en,
  output logic        busy,
  output logic        done
);

`ifdef RGB2YUV_ROUND_EN
  localparam logic signed [18:0] Rnd = 19'sd128;
`else
  localparam logic signed [18:0] Rnd = 19'sd0;
`endif

  localparam logic [19:0] LastPair = 20'(PIXEL_PAIRS - 1);

  typedef enum logic [3:0] {
    StIdle,
    StRdR,
    StRdG,
    StRdB,
    StCapB,
    StWrY,
    StWrU,
    StWrV,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] k_q, k_d;
  logic [15:0] r_q, r_d;
  logic [15:0] g_q, g_d;
  logic [15:0] b_q, b_d;
  logic [19:0] r_addr_q, r_addr_d;
  logic [19:0] w_addr_q, w_addr_d;
  logic [15:0] w_data_q, w_data_d;
  logic        w_en_q, w_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [19:0] src_base;
  logic [23:0] pix_even, pix_odd;

  // Clamp a signed intermediate to the 0..255 pixel range.
  function automatic logic [7:0] sat8(input logic signed [18:0] x);
    if (x < 19'sd0) begin
      return 8'd0;
    end else if (x > 19'sd255) begin
      return 8'hff;
    end else begin
      return x[7:0];
    end
  endfunction

  // One pixel conversion, returns {Y, U, V}.
  function automatic logic [23:0] to_yuv(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    logic signed [18:0] rs, gs, bs, y, u, v;
    rs = signed'({11'd0, r});
    gs = signed'({11'd0, g});
    bs = signed'({11'd0, b});
    y  = (19'sd77 * rs + 19'sd150 * gs + 19'sd29 * bs + Rnd) >>> 8;
    u  = ((19'sd128 * bs - 19'sd43 * rs - 19'sd85 * gs + Rnd) >>> 8) + 19'sd128;
    v  = ((19'sd128 * rs - 19'sd107 * gs - 19'sd21 * bs + Rnd) >>> 8) + 19'sd128;
    return {sat8(y), sat8(u), sat8(v)};
  endfunction

  // Next-state, pixel capture and registered-output computation.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    r_addr_d = r_addr_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    w_en_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        k_d = 20'd0;
        if (start) state_d = StRdR;
      end
      StRdR:  state_d = StRdG;
      StRdG: begin
        r_d     = R_data;
        state_d = StRdB;
      end
      StRdB: begin
        g_d     = R_data;
        state_d = StCapB;
      end
      StCapB: begin
        b_d     = R_data;
        state_d = StWrY;
      end
      StWrY:  state_d = StWrU;
      StWrU:  state_d = StWrV;
      StWrV: begin
        if (k_q == LastPair) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + 20'd1;
          state_d = StRdR;
        end
      end
      StDone: begin
        k_d     = 20'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    src_base = {k_d[18:0], 1'b0} + k_d;
    pix_even = to_yuv(r_q[7:0], g_q[7:0], b_d[7:0]);
    pix_odd  = to_yuv(r_q[15:8], g_q[15:8], b_d[15:8]);

    unique case (state_d)
      StRdR: r_addr_d = src_base;
      StRdG: r_addr_d = src_base + 20'd1;
      StRdB: r_addr_d = src_base + 20'd2;
      StWrY: begin
        w_en_d   = 1'b1;
        w_addr_d = Y_BASE + k_d;
        w_data_d = {pix_odd[23:16], pix_even[23:16]};
      end
      StWrU: begin
        w_en_d   = 1'b1;
        w_addr_d = U_BASE + k_d;
        w_data_d = {pix_odd[15:8], pix_even[15:8]};
      end
      StWrV: begin
        w_en_d   = 1'b1;
        w_addr_d = V_BASE + k_d;
        w_data_d = {pix_odd[7:0], pix_even[7:0]};
      end
      StDone: done_d = 1'b1;
      default: ;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset clears everything immediately, even mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      k_q      <= 20'd0;
      r_q      <= 16'd0;
      g_q      <= 16'd0;
      b_q      <= 16'd0;
      r_addr_q <= 20'd0;
      w_addr_q <= 20'd0;
      w_data_q <= 16'd0;
      w_en_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      r_addr_q <= r_addr_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_en_q   <= w_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign R_addr = r_addr_q;
  assign W_addr = w_addr_q;
  assign W_data = w_data_q;
  assign W_en   = w_en_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_rgb_to_yuv_converter.sv
// Self-checking bench for rgb_to_yuv_converter: two-pair frames with directed colours,
// random pixels, start re-assertion while busy and a mid-frame reset abort.
module tb_rgb_to_yuv_converter;

  localparam int unsigned Pairs = 2;
  localparam logic [19:0] YBase = 20'h00100;
  localparam logic [19:0] UBase = 20'h00200;
  localparam logic [19:0] VBase = 20'h00300;

`ifdef RGB2YUV_ROUND_EN
  localparam int TbRnd = 128;
`else
  localparam int TbRnd = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] R_data = 16'd0;
  logic [19:0] R_addr, W_addr;
  logic [15:0] W_data;
  logic        W_en, busy, done;

  logic [15:0] mem [0:7];
  logic [19:0] addr_hold = 20'd0;

  logic [19:0] got_a [$];
  logic [15:0] got_d [$];

  int n_checks = 0;
  int n_errors = 0;

  rgb_to_yuv_converter #(
    .PIXEL_PAIRS(Pairs),
    .Y_BASE     (YBase),
    .U_BASE     (UBase),
    .V_BASE     (VBase)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .R_data(R_data),
    .R_addr(R_addr),
    .W_addr(W_addr),
    .W_data(W_data),
    .W_en  (W_en),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Source memory: data for an address appears one cycle after the address.
  always @(negedge clk) begin
    R_data    = mem[addr_hold[2:0]];
    addr_hold = R_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Floor division by 256 on plain integers.
  function automatic int fdiv256(input int x);
    if (x >= 0) return x / 256;
    return -((-x + 255) / 256);
  endfunction

  function automatic int clamp255(input int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  // ch: 0 = Y, 1 = U, 2 = V
  function automatic int ref_pix(input int ch, input int r, input int g, input int b);
    case (ch)
      0:       return clamp255(fdiv256(77 * r + 150 * g + 29 * b + TbRnd));
      1:       return clamp255(fdiv256(-43 * r - 85 * g + 128 * b + TbRnd) + 128);
      default: return clamp255(fdiv256(128 * r - 107 * g - 21 * b + TbRnd) + 128);
    endcase
  endfunction

  function automatic logic [15:0] ref_word(input int k, input int ch);
    logic [15:0] rw, gw, bw;
    int lo, hi;
    rw = mem[3 * k];
    gw = mem[3 * k + 1];
    bw = mem[3 * k + 2];
    lo = ref_pix(ch, int'(rw[7:0]), int'(gw[7:0]), int'(bw[7:0]));
    hi = ref_pix(ch, int'(rw[15:8]), int'(gw[15:8]), int'(bw[15:8]));
    return {hi[7:0], lo[7:0]};
  endfunction

  // One full frame from a start pulse; collects writes and checks timing and contents.
  task automatic run_frame(input bit poke_start);
    int done_at;
    int busy_low;
    int extra;
    logic [19:0] bases [3];
    bases[0] = YBase;
    bases[1] = UBase;
    bases[2] = VBase;
    done_at  = -1;
    busy_low = 0;
    extra    = 0;
    got_a.delete();
    got_d.delete();
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = poke_start && (i % 3 == 0);
      if (done) begin
        done_at = i;
        break;
      end
      if (!busy) busy_low++;
      if (W_en) begin
        got_a.push_back(W_addr);
        got_d.push_back(W_data);
      end
    end
    start = 1'b0;
    check("done_cycle", done_at, 15);
    check("busy_low_cycles", busy_low, 0);
    check("write_count", got_a.size(), 6);
    for (int j = 0; j < 6 && j < got_a.size(); j++) begin
      check("write_addr", got_a[j], bases[j % 3] + 20'(j / 3));
      check("write_data", got_d[j], ref_word(j / 3, j % 3));
    end
    repeat (6) begin
      @(negedge clk);
      if (W_en || busy || done) extra++;
    end
    check("idle_after_done", extra, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_w_en", W_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_r_addr", R_addr, 0);
    check("rst_w_addr", W_addr, 0);
    check("rst_w_data", W_data, 0);
    rst = 1'b1;
    @(negedge clk);

    // White pair then red-even/black-odd pair.
    mem[0] = 16'hFFFF; mem[1] = 16'hFFFF; mem[2] = 16'hFFFF;
    mem[3] = 16'h00FF; mem[4] = 16'h0000; mem[5] = 16'h0000;
    run_frame(1'b0);
    check("white_y", got_d[0], 16'hFFFF);
    check("white_u", got_d[1], 16'h8080);
    check("white_v", got_d[2], 16'h8080);
`ifdef RGB2YUV_ROUND_EN
    check("red_y", got_d[3], 16'h004D);
`else
    check("red_y", got_d[3], 16'h004C);
`endif
    check("red_u", got_d[4], 16'h8055);
    check("red_v", got_d[5], 16'h80FF);

    // Blue pair then a random pair.
    mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'h00FF;
    mem[3] = 16'($urandom); mem[4] = 16'($urandom); mem[5] = 16'($urandom);
    run_frame(1'b0);
`ifdef RGB2YUV_ROUND_EN
    check("blue_y", got_d[0], 16'h001D);
`else
    check("blue_y", got_d[0], 16'h001C);
`endif
    check("blue_u", got_d[1], 16'h80FF);
    check("blue_v", got_d[2], 16'h806B);

    // Random frames; one with start pulsed repeatedly while busy.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 6; i++) mem[i] = 16'($urandom);
      run_frame(f == 3);
    end

    // Abort during WR_U of pair 1 (cycle 13 after the start cycle).
    for (int i = 0; i < 6; i++) mem[i] = 16'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_pre_w_en", W_en, 1);
    check("abort_pre_w_addr", W_addr, UBase + 20'd1);
    rst = 1'b0;
    #1;
    check("abort_w_en", W_en, 0);
    check("abort_busy", busy, 0);
    check("abort_w_addr", W_addr, 0);
    check("abort_w_data", W_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle_busy", busy, 0);
    for (int i = 0; i < 6; i++) mem[i] = 16'($urandom);
    run_frame(1'b0);
    check("restart_first_addr", got_a[0], YBase);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rgb_to_yuv_converter.md
RGB_TO_YUV_CONVERTER -- requirements
Module: rgb_to_yuv_converter

Interface
REQ-001 SHALL have parameter PIXEL_PAIRS, default 38400, number of two-pixel words per plane.
REQ-002 SHALL have parameter Y_BASE, default 20'd0, write address of the first Y-plane word.
REQ-003 SHALL have parameter U_BASE, default 20'd38400, write address of the first U-plane word.
REQ-004 SHALL have parameter V_BASE, default 20'd76800, write address of the first V-plane word.
REQ-005 SHALL have port clk  input  1  system clock, rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle request to convert a frame.
REQ-008 SHALL have port R_data  input  16  read data, valid the cycle after R_addr is presented.
REQ-009 SHALL have port R_addr  output  20  RGB source read address.
REQ-010 SHALL have port W_addr  output  20  YUV destination write address.
REQ-011 SHALL have port W_data  output  16  write data, {odd pixel [15:8], even pixel [7:0]}.
REQ-012 SHALL have port W_en  output  1  write strobe, one word per high cycle.
REQ-013 SHALL have port busy  output  1  high from start acceptance until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the last V word has been written.

Function
REQ-015 SHALL treat source word 3k as {R_odd,R_even}, word 3k+1 as {G_odd,G_even} and word 3k+2 as {B_odd,B_even} for pair k, 0 <= k < PIXEL_PAIRS.
REQ-016 SHALL use FSM states IDLE, RD_R, RD_G, RD_B, CAP_B, WR_Y, WR_U, WR_V and DONE.
REQ-017 SHALL leave IDLE for RD_R only when start=1; start in any other state SHALL be ignored.
REQ-018 SHALL drive R_addr=3k in RD_R, 3k+1 in RD_G and 3k+2 in RD_B, capturing R in RD_G, G in RD_B and B in CAP_B.
REQ-019 SHALL assert W_en in WR_Y, WR_U and WR_V with W_addr equal to Y_BASE+k, U_BASE+k and V_BASE+k respectively, giving 7 cycles per pair.
REQ-020 SHALL compute Y=(77R+150G+29B+rnd)>>>8, U=((-43R-85G+128B+rnd)>>>8)+128 and V=((128R-107G-21B+rnd)>>>8)+128 in signed arithmetic of at least 18 bits.
REQ-021 SHALL saturate each of Y, U and V to 0..255 before packing.
REQ-022 SHALL go from WR_V to DONE when k=PIXEL_PAIRS-1, and otherwise increment k and go to RD_R.
REQ-023 SHALL pulse done for the single DONE cycle, then return to IDLE with k=0.
REQ-024 SHALL hold W_en=0 in every state except WR_Y, WR_U and WR_V.

Reset
REQ-025 SHALL, on rst=0 at any time including mid-frame, immediately force state IDLE, k=0, R_addr=0, W_addr=0, W_data=0, W_en=0, busy=0, done=0 and all pixel registers to 0.
REQ-026 SHALL restart from pair 0 on the first start after reset is released, without resuming the aborted frame.

Configuration
REQ-027 SHALL, when macro RGB2YUV_ROUND_EN is defined, use rnd=128 (round to nearest).
REQ-028 SHALL, when RGB2YUV_ROUND_EN is undefined, use rnd=0 (truncate toward minus infinity); all other behaviour is unchanged.

Verification
REQ-029 SHALL cover white: R=G=B=0xFFFF -> Y word 0xFFFF, U word 0x8080, V word 0x8080.
REQ-030 SHALL cover red even/black odd: R=0x00FF, G=0, B=0 with ROUND_EN defined -> Y 0x004D, U 0x8055, V 0x80FF (V saturated); with ROUND_EN undefined -> Y 0x004C.
REQ-031 SHALL cover blue: B=0x00FF, R=G=0 with ROUND_EN defined -> Y 0x001D, U 0x80FF (saturated), V 0x806B.
REQ-032 SHALL cover timing with PIXEL_PAIRS=2: one start -> exactly 6 W_en pulses at addresses Y_BASE, U_BASE, V_BASE, Y_BASE+1, U_BASE+1, V_BASE+1; done 15 cycles after the start cycle; busy high throughout.
REQ-033 SHALL cover start re-asserted while busy -> no restart, no extra writes.
REQ-034 SHALL cover rst=0 during WR_U of pair 1 -> W_en=0 in the same cycle; the next start writes Y_BASE+0 first.
